// File: rtl/fwd_track_pipe.sv
// Destination-register tracking pipe: carries {rd, we, ld} through DEPTH stages,
// resolves operand forwarding per source and raises a load-use stall.
// Optional statistics counters are enabled by defining FWD_TRACK_STAT_EN.
module fwd_track_pipe #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned LD_LAT = 1,
  localparam int unsigned SW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pause,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_we,
  input  logic                 id_ld,
  input  logic [NSRC*AW-1:0]   src_n_i,
  input  logic [NSRC*DW-1:0]   rf_data_i,
  input  logic [DEPTH*DW-1:0]  stg_data_i,
  output logic [NSRC*SW-1:0]   fw_sel_o,
  output logic [NSRC*DW-1:0]   fw_data_o,
  output logic                 stall_o,
  output logic [AW-1:0]        wb_rd_o,
  output logic                 wb_we_o
`ifdef FWD_TRACK_STAT_EN
  ,
  output logic [31:0]          stat_fw_o,
  output logic [31:0]          stat_stall_o
`endif
);

  logic [AW-1:0]    st_rd [DEPTH];
  logic [DEPTH-1:0] st_we;
  logic [DEPTH-1:0] st_ld;
  logic [NSRC-1:0]  hazard;
  logic [NSRC-1:0]  found;
  logic             bubble;

  assign bubble = flush | stall_o | ~id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        st_rd[k] <= '0;
      end
      st_we <= '0;
      st_ld <= '0;
    end else if (!pause) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        st_rd[k] <= st_rd[k-1];
        st_we[k] <= st_we[k-1];
        st_ld[k] <= st_ld[k-1];
      end
      if (bubble) begin
        st_rd[0] <= '0;
        st_we[0] <= 1'b0;
        st_ld[0] <= 1'b0;
      end else begin
        st_rd[0] <= id_rd;
        st_we[0] <= id_we & (id_rd != '0);
        st_ld[0] <= id_ld;
      end
    end
  end

  // Scan stages youngest-first; the first hit latches and older hits are ignored.
  always_comb begin
    found     = '0;
    hazard    = '0;
    fw_sel_o  = '0;
    fw_data_o = rf_data_i;
    for (int unsigned j = 0; j < NSRC; j++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!found[j] && st_we[k] && (src_n_i[j*AW +: AW] != '0) &&
            (st_rd[k] == src_n_i[j*AW +: AW])) begin
          found[j] = 1'b1;
          if (st_ld[k] && (k < LD_LAT)) begin
            hazard[j] = 1'b1;
          end else begin
            fw_sel_o[j*SW +: SW]  = SW'(k + 1);
            fw_data_o[j*DW +: DW] = stg_data_i[k*DW +: DW];
          end
        end
      end
    end
  end

  assign stall_o = |hazard;
  assign wb_rd_o = st_rd[DEPTH-1];
  assign wb_we_o = st_we[DEPTH-1];

`ifdef FWD_TRACK_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fw_o    <= '0;
      stat_stall_o <= '0;
    end else if (!pause) begin
      if ((|fw_sel_o) && !stall_o && (stat_fw_o != '1)) begin
        stat_fw_o <= stat_fw_o + 32'd1;
      end
      if (stall_o && (stat_stall_o != '1)) begin
        stat_stall_o <= stat_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_track_pipe.sv
// Directed self-checking bench for fwd_track_pipe (DEPTH=3, NSRC=2, LD_LAT=1).
module tb_fwd_track_pipe;

  localparam logic [31:0] RF0 = 32'hF000_0000;
  localparam logic [31:0] RF1 = 32'hF111_1111;
  localparam logic [31:0] S0  = 32'hA000_0000;
  localparam logic [31:0] S1  = 32'hB111_1111;
  localparam logic [31:0] S2  = 32'hC222_2222;

  logic        clk = 1'b0;
  logic        rst, pause, flush, id_valid, id_we, id_ld;
  logic [4:0]  id_rd, src0, src1;
  logic [9:0]  src_n_i;
  logic [63:0] rf_data_i;
  logic [95:0] stg_data_i;
  logic [3:0]  fw_sel_o;
  logic [63:0] fw_data_o;
  logic        stall_o, wb_we_o;
  logic [4:0]  wb_rd_o;
`ifdef FWD_TRACK_STAT_EN
  logic [31:0] stat_fw_o, stat_stall_o;
`endif

  logic [1:0]  sel0, sel1;
  logic [31:0] data0, data1;
  int n_cmp = 0;
  int n_bad = 0;

  assign src_n_i    = {src1, src0};
  assign rf_data_i  = {RF1, RF0};
  assign stg_data_i = {S2, S1, S0};
  assign sel0  = fw_sel_o[1:0];
  assign sel1  = fw_sel_o[3:2];
  assign data0 = fw_data_o[31:0];
  assign data1 = fw_data_o[63:32];

  fwd_track_pipe #(.DEPTH(3), .NSRC(2), .DW(32), .AW(5), .LD_LAT(1)) dut (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush), .id_valid(id_valid),
    .id_rd(id_rd), .id_we(id_we), .id_ld(id_ld), .src_n_i(src_n_i),
    .rf_data_i(rf_data_i), .stg_data_i(stg_data_i), .fw_sel_o(fw_sel_o),
    .fw_data_o(fw_data_o), .stall_o(stall_o), .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o)
`ifdef FWD_TRACK_STAT_EN
    , .stat_fw_o(stat_fw_o), .stat_stall_o(stat_stall_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic ld);
    id_valid = 1'b1; id_rd = rd; id_we = we; id_ld = ld;
    tick();
    id_valid = 1'b0; id_rd = '0; id_we = 1'b0; id_ld = 1'b0;
  endtask

  task automatic drain();
    src0 = '0; src1 = '0; id_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    src0 = 5'd1; src1 = 5'd2; #1;
    n_cmp++; if (sel0 !== 2'd0) begin n_bad++; $display("FAIL rst_sel0 got %0d want 0", sel0); end
    n_cmp++; if (data1 !== RF1) begin n_bad++; $display("FAIL rst_data1 got %h want %h", data1, RF1); end
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", stall_o); end
    n_cmp++; if ({wb_we_o, wb_rd_o} !== 6'd0) begin n_bad++; $display("FAIL rst_wb got %b/%0d want 0/0", wb_we_o, wb_rd_o); end
    src0 = '0; src1 = '0;
    issue(5'd1, 1'b1, 1'b0);
    issue(5'd2, 1'b1, 1'b0);
    issue(5'd3, 1'b1, 1'b0);
    n_cmp++; if ({wb_we_o, wb_rd_o} !== {1'b1, 5'd1}) begin n_bad++; $display("FAIL fill_wb got %b/%0d want 1/1", wb_we_o, wb_rd_o); end
    src0 = 5'd3; src1 = 5'd2; #1;
    n_cmp++; if ({sel1, sel0} !== {2'd2, 2'd1}) begin n_bad++; $display("FAIL fill_sel got %0d/%0d want 2/1", sel1, sel0); end
    rst = 1'b1; #1;
    n_cmp++; if (wb_we_o !== 1'b0) begin n_bad++; $display("FAIL async_wb_we got %b want 0", wb_we_o); end
    n_cmp++; if (fw_sel_o !== 4'd0) begin n_bad++; $display("FAIL async_fw_sel got %h want 0", fw_sel_o); end
    tick();
    rst = 1'b0;
    src0 = 5'd1; src1 = 5'd3; #1;
    n_cmp++; if (fw_sel_o !== 4'd0) begin n_bad++; $display("FAIL post_rst_sel got %h want 0", fw_sel_o); end
    n_cmp++; if (wb_rd_o !== 5'd0) begin n_bad++; $display("FAIL post_rst_wb_rd got %0d want 0", wb_rd_o); end
`ifdef FWD_TRACK_STAT_EN
    n_cmp++; if (stat_fw_o !== 32'd0) begin n_bad++; $display("FAIL rst_stat_fw got %0d want 0", stat_fw_o); end
`endif
    src0 = '0; src1 = '0;
  endtask

  task automatic test_alu_forward();
    issue(5'd5, 1'b1, 1'b0);
    src0 = 5'd5; #1;
    n_cmp++; if (sel0 !== 2'd1) begin n_bad++; $display("FAIL alu_sel0 got %0d want 1", sel0); end
    n_cmp++; if (data0 !== S0) begin n_bad++; $display("FAIL alu_data0 got %h want %h", data0, S0); end
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL alu_stall got %b want 0", stall_o); end
    tick();
    n_cmp++; if ({sel0, data0} !== {2'd2, S1}) begin n_bad++; $display("FAIL alu_stage1 got %0d/%h want 2/%h", sel0, data0, S1); end
    drain();
  endtask

  task automatic test_youngest_wins();
    issue(5'd7, 1'b1, 1'b0);
    tick();
    issue(5'd7, 1'b1, 1'b0);
    src1 = 5'd7; #1;
    n_cmp++; if (sel1 !== 2'd1) begin n_bad++; $display("FAIL young_sel1 got %0d want 1", sel1); end
    n_cmp++; if (data1 !== S0) begin n_bad++; $display("FAIL young_data1 got %h want %h", data1, S0); end
    n_cmp++; if (sel0 !== 2'd0) begin n_bad++; $display("FAIL young_sel0 got %0d want 0", sel0); end
    n_cmp++; if (wb_rd_o !== 5'd7) begin n_bad++; $display("FAIL young_wb_rd got %0d want 7", wb_rd_o); end
    drain();
  endtask

  task automatic test_load_use();
    issue(5'd9, 1'b1, 1'b1);
    id_valid = 1'b1; id_rd = 5'd10; id_we = 1'b1; id_ld = 1'b0;
    src0 = 5'd9; #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %b want 1", stall_o); end
    n_cmp++; if ({sel0, data0} !== {2'd0, RF0}) begin n_bad++; $display("FAIL lu_sel0 got %0d/%h want 0/%h", sel0, data0, RF0); end
    tick();
    src1 = 5'd10; #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL lu_stall_next got %b want 0", stall_o); end
    n_cmp++; if ({sel0, data0} !== {2'd2, S1}) begin n_bad++; $display("FAIL lu_fwd got %0d/%h want 2/%h", sel0, data0, S1); end
    n_cmp++; if (sel1 !== 2'd0) begin n_bad++; $display("FAIL lu_bubble got %0d want 0", sel1); end
    tick();
    n_cmp++; if ({sel1, sel0} !== {2'd1, 2'd3}) begin n_bad++; $display("FAIL lu_resume got %0d/%0d want 1/3", sel1, sel0); end
    n_cmp++; if ({wb_we_o, wb_rd_o} !== {1'b1, 5'd9}) begin n_bad++; $display("FAIL lu_wb got %b/%0d want 1/9", wb_we_o, wb_rd_o); end
    id_valid = 1'b0; id_rd = '0; id_we = 1'b0;
    src0 = '0; src1 = '0;
  endtask

  task automatic test_stats();
`ifdef FWD_TRACK_STAT_EN
    n_cmp++; if (stat_fw_o !== 32'd2) begin n_bad++; $display("FAIL stat_fw got %0d want 2", stat_fw_o); end
    n_cmp++; if (stat_stall_o !== 32'd1) begin n_bad++; $display("FAIL stat_stall got %0d want 1", stat_stall_o); end
`endif
    drain();
  endtask

  task automatic test_pause_flush();
    issue(5'd12, 1'b1, 1'b0);
    issue(5'd11, 1'b1, 1'b1);
    pause = 1'b1; flush = 1'b1;
    id_valid = 1'b1; id_rd = 5'd13; id_we = 1'b1;
    src0 = 5'd11; src1 = 5'd12; #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL pause_stall_in got %b want 1", stall_o); end
    repeat (4) tick();
    n_cmp++; if ({stall_o, sel0} !== {1'b1, 2'd0}) begin n_bad++; $display("FAIL pause_hold0 got %b/%0d want 1/0", stall_o, sel0); end
    n_cmp++; if ({sel1, data1} !== {2'd2, S1}) begin n_bad++; $display("FAIL pause_hold1 got %0d/%h want 2/%h", sel1, data1, S1); end
`ifdef FWD_TRACK_STAT_EN
    n_cmp++; if ({stat_fw_o, stat_stall_o} !== {32'd2, 32'd1}) begin n_bad++; $display("FAIL pause_stat got %0d/%0d want 2/1", stat_fw_o, stat_stall_o); end
`endif
    pause = 1'b0;
    tick();
    n_cmp++; if ({stall_o, sel0, sel1} !== {1'b0, 2'd2, 2'd3}) begin n_bad++; $display("FAIL flush_stall_one got %b/%0d/%0d want 0/2/3", stall_o, sel0, sel1); end
    flush = 1'b0;
    tick();
    src0 = 5'd13; src1 = 5'd11; #1;
    n_cmp++; if ({sel0, sel1} !== {2'd1, 2'd3}) begin n_bad++; $display("FAIL flush_after got %0d/%0d want 1/3", sel0, sel1); end
    n_cmp++; if (wb_rd_o !== 5'd11) begin n_bad++; $display("FAIL flush_wb_rd got %0d want 11", wb_rd_o); end
    flush = 1'b1; id_rd = 5'd14;
    tick();
    flush = 1'b0; id_valid = 1'b0;
    src0 = 5'd14; #1;
    n_cmp++; if (sel0 !== 2'd0) begin n_bad++; $display("FAIL flush_only got %0d want 0", sel0); end
    id_rd = '0; id_we = 1'b0;
    drain();
  endtask

  task automatic test_r0();
    issue(5'd0, 1'b1, 1'b0);
    issue(5'd0, 1'b1, 1'b1);
    #1;
    n_cmp++; if ({stall_o, fw_sel_o} !== 5'd0) begin n_bad++; $display("FAIL r0_src got %b/%h want 0/0", stall_o, fw_sel_o); end
    tick();
    n_cmp++; if (wb_we_o !== 1'b0) begin n_bad++; $display("FAIL r0_wb_we got %b want 0", wb_we_o); end
    issue(5'd14, 1'b0, 1'b0);
    src0 = 5'd14; #1;
    n_cmp++; if (sel0 !== 2'd0) begin n_bad++; $display("FAIL nowe_sel got %0d want 0", sel0); end
    drain();
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rd = '0; id_we = 1'b0; id_ld = 1'b0;
    src0 = '0; src1 = '0;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_alu_forward();
    test_youngest_wins();
    test_load_use();
    test_stats();
    test_pause_flush();
    test_r0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
